keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Drives a 4x4 matrix keypad and produces the debounced 16-bit `button` vector consumed by the button decoder.
- Sequences one active-low column at a time and samples the rows.
- Assembles a full 16-key frame per scan and commits a new debounced state only after the frame has been stable for DEBOUNCE_SCANS consecutive scans.
- Emits a one-cycle `key_valid` strobe with the key index on each new single-key press.

Parameters:
- SCAN_DIV, 2080, clk_i cycles per column dwell (1 ms at 2.08 MHz); minimum 4.
- DEBOUNCE_SCANS, 20, consecutive identical frames required before commit; minimum 1.

Ports:
- clk_i  input  1  system clock (2.08 MHz oscillator).
- reset  input  1  synchronous, active-high reset.
- row_i  input  4  raw keypad rows, active-low, asynchronous, externally pulled up.
- col_o  output  4  column drive, active-low, exactly one bit low at all times.
- button  output  16  debounced key state; bit 4*c+r set = key (col c, row r) held; one-hot or zero only.
- key_code  output  4  index 4*c+r of the most recently committed single press; holds until the next one.
- key_valid  output  1  one-cycle pulse when a new single-key press is committed.
- multi_press  output  1  level, high while the committed frame has two or more keys down.

Behaviour:
- Reset (synchronous, active-high): the following values apply on the first edge with reset high:
  - col_o=4'b1110 (COL0).
  - Dwell counter 0, frame/prev_frame/stable count 0.
  - button=0, key_code=0, key_valid=0, multi_press=0.
  - Synchronizer flops reset to 4'b1111.
  - A reset mid-scan or mid-debounce discards all partial state.
- Synchronizer: row_i passes through 2 flops before use; this 2-cycle delay is why SCAN_DIV must be at least 4.
- Column FSM, states COL0..COL3:
  - Each state lasts exactly SCAN_DIV cycles, then advances COL0->COL1->COL2->COL3->COL0.
  - col_o is registered and low only for the current column: COL0=1110, COL1=1101, COL2=1011, COL3=0111.
- Sampling:
  - On the last dwell cycle of column c, frame[4c+r] = ~row_sync[r] for r=0..3.
  - The frame is complete at the sample of COL3. Frame period = 4*SCAN_DIV cycles.
- Debounce, evaluated on the frame-complete cycle:
  - If frame==prev_frame: cnt=min(cnt+1, DEBOUNCE_SCANS); otherwise cnt=0.
  - prev_frame<=frame.
  - Commit occurs only on the cycle cnt goes from DEBOUNCE_SCANS-1 to DEBOUNCE_SCANS.
  - A press first appearing in frame k commits at the end of frame k+DEBOUNCE_SCANS.
  - Outputs update one cycle after that frame-complete cycle.
- Commit rules by key count in the frame:
  - 0 keys: button=0, multi_press=0, no pulse, key_code holds.
  - Exactly 1 key: button=frame, multi_press=0, key_code=index. key_valid pulses for 1 cycle only if the new button differs from the previous committed button.
  - 2 or more keys: button=0, multi_press=1, no pulse, key_code holds.
- Saturated cnt: holds at DEBOUNCE_SCANS and causes no re-commit, so a held key yields exactly one pulse.
- Toggle case: a frame change during counting resets cnt to 0. Bounces shorter than DEBOUNCE_SCANS frames never change outputs.
- Key change: a direct change from key A to key B after a stable period commits B with a new pulse.
- Outputs are fully registered; no combinational path from row_i.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, frame=16 cycles; the bench keypad model pulls row r low when col_o[c]=0 and key (c,r) is down):
- Reset: hold reset 3 cycles, then release. Required: col_o=1110, button=0, key_valid=0, multi_press=0. col_o then steps 1101, 1011, 0111, 1110 every 4 cycles.
- Hold key 5 (c1,r1) from reset. Required: frames 0..3 capture it; at the end of frame 3, button=16'h0020, key_code=5, key_valid high exactly 1 cycle. No further pulses over 10 more frames.
- Press key 9 for 2 frames, release for 1, press for 2. Required: button stays 0 and key_valid never asserts.
- Release key 5 after commit. Required: button=0 after 3 stable frames, key_code stays 5, no key_valid.
- Hold keys 0 and 15 together. Required: multi_press=1, button=0, no pulse. Then release key 0. Required: after 3 frames, button=16'h8000, key_code=15, multi_press=0, key_valid pulses once.
- Assert reset while key 3 is committed and held. Required: all outputs 0 next cycle and col_o=1110. After release, recommit of key 3 with key_valid occurs only after a full 4-frame debounce.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: one column driven low per dwell period,
// rows synchronised and assembled into a 16-key frame, frames debounced before commit.
module keypad_scanner #(
    parameter int SCAN_DIV       = 2080,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic [3:0]  row_i,
    output logic [3:0]  col_o,
    output logic [15:0] button,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        multi_press
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DEBOUNCE_SCANS - 1);

    typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_state_t;

    col_state_t       state;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       row_p0;
    logic [3:0]       row_p1;
    logic [15:0]      frame;
    logic [15:0]      prev_frame;
    logic [15:0]      frame_full;
    logic [CNT_W-1:0] cnt;

    function automatic logic is_single(input logic [15:0] f);
        return (f != 16'h0000) && ((f & (f - 16'd1)) == 16'h0000);
    endfunction

    function automatic logic [3:0] key_index(input logic [15:0] f);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (f[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // The COL3 sample completes the frame in the same cycle it is evaluated.
    assign frame_full = {~row_p1, frame[11:0]};

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state       <= COL0;
            col_o       <= 4'b1110;
            div_cnt     <= '0;
            row_p0      <= 4'hF;
            row_p1      <= 4'hF;
            frame       <= '0;
            prev_frame  <= '0;
            cnt         <= '0;
            button      <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            multi_press <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            row_p0    <= row_i;
            row_p1    <= row_p0;

            if (div_cnt != DIV_LAST) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end else begin
                div_cnt <= '0;
                case (state)
                    COL0: begin
                        frame[3:0] <= ~row_p1;
                        state      <= COL1;
                        col_o      <= 4'b1101;
                    end
                    COL1: begin
                        frame[7:4] <= ~row_p1;
                        state      <= COL2;
                        col_o      <= 4'b1011;
                    end
                    COL2: begin
                        frame[11:8] <= ~row_p1;
                        state       <= COL3;
                        col_o       <= 4'b0111;
                    end
                    COL3: begin
                        frame[15:12] <= ~row_p1;
                        state        <= COL0;
                        col_o        <= 4'b1110;
                        prev_frame   <= frame_full;
                        if (frame_full == prev_frame) begin
                            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
                            // Commit only on the transition into saturation.
                            if (cnt == CNT_PRE) begin
                                if (frame_full == 16'h0000) begin
                                    button      <= '0;
                                    multi_press <= 1'b0;
                                end else if (is_single(frame_full)) begin
                                    button      <= frame_full;
                                    multi_press <= 1'b0;
                                    key_code    <= key_index(frame_full);
                                    key_valid   <= (frame_full != button);
                                end else begin
                                    button      <= '0;
                                    multi_press <= 1'b1;
                                end
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                    default: begin
                        state <= COL0;
                        col_o <= 4'b1110;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised keypad bench: a frame-level debounce model feeds expectation queues,
// and an independent monitor checks column drive, committed state and press strobes.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DS = 3;
    localparam int FR = 4 * SD;

    logic        clk_i = 1'b0;
    logic        reset;
    logic [3:0]  row_i;
    logic [3:0]  col_o;
    logic [15:0] button;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        multi_press;
    logic [15:0] keys;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] btn;
        logic        mp;
        logic [3:0]  code;
    } state_t;

    typedef struct {
        int         n;
        logic [3:0] code;
    } pulse_t;

    state_t state_q[$];
    pulse_t pulse_q[$];

    logic [15:0] m_prev;
    logic [15:0] m_btn;
    logic        m_mp;
    logic [3:0]  m_code;
    int          m_cnt;
    int          m_frame;

    int          mon_n;
    int          mon_c;
    logic [3:0]  mon_col;
    state_t      mon_s;
    pulse_t      mon_p;

    always #5 clk_i = ~clk_i;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk_i       (clk_i),
        .reset       (reset),
        .row_i       (row_i),
        .col_o       (col_o),
        .button      (button),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .multi_press (multi_press)
    );

    // Physical keypad: a held key shorts its row to a column that is driven low.
    always_comb begin
        row_i = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col_o[c] && keys[4*c+r]) row_i[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] idx_of(input logic [15:0] f);
        logic [3:0] k;
        k = 4'd0;
        for (int i = 0; i < 16; i++) if (f[i]) k = 4'(i);
        return k;
    endfunction

    // Frame-level reference: one call per 16-key frame the keypad presents.
    task automatic model_frame(input logic [15:0] f);
        state_t s;
        pulse_t p;
        if (f == m_prev) begin
            if (m_cnt < DS) begin
                m_cnt++;
                if (m_cnt == DS) begin
                    if ($countones(f) == 1) begin
                        if (f != m_btn) begin
                            p.n    = FR * m_frame + FR - 1;
                            p.code = idx_of(f);
                            pulse_q.push_back(p);
                        end
                        m_btn  = f;
                        m_mp   = 1'b0;
                        m_code = idx_of(f);
                    end else if (f == 16'h0000) begin
                        m_btn = 16'h0000;
                        m_mp  = 1'b0;
                    end else begin
                        m_btn = 16'h0000;
                        m_mp  = 1'b1;
                    end
                end
            end
        end else begin
            m_cnt = 0;
        end
        m_prev = f;
        s.btn  = m_btn;
        s.mp   = m_mp;
        s.code = m_code;
        state_q.push_back(s);
        m_frame++;
    endtask

    task automatic run_frame(input logic [15:0] f);
        keys = f;
        model_frame(f);
        repeat (FR) @(posedge clk_i);
        #2;
    endtask

    task automatic run_hold(input logic [15:0] f, input int frames);
        for (int i = 0; i < frames; i++) run_frame(f);
    endtask

    task automatic do_reset(input int cycles);
        chk("pulse_q_empty_at_reset", pulse_q.size(), 0);
        reset = 1'b1;
        repeat (cycles) @(posedge clk_i);
        #2;
        reset   = 1'b0;
        m_prev  = '0;
        m_btn   = '0;
        m_mp    = 1'b0;
        m_code  = '0;
        m_cnt   = 0;
        m_frame = 0;
    endtask

    // Monitor: cycle index since reset release locates column and frame boundaries.
    initial begin
        mon_n = -1;
        forever begin
            @(posedge clk_i);
            if (reset) mon_n = -1;
            else mon_n++;
            @(negedge clk_i);
            if (mon_n < 0) begin
                chk("reset_col_o", col_o, 4'b1110);
                chk("reset_button", button, 0);
                chk("reset_key_code", key_code, 0);
                chk("reset_key_valid", key_valid, 0);
                chk("reset_multi_press", multi_press, 0);
            end else begin
                mon_c   = ((mon_n + 1) / SD) % 4;
                mon_col = 4'hF;
                mon_col[mon_c] = 1'b0;
                chk("col_o", col_o, mon_col);
                if (mon_n % FR == FR - 1) begin
                    if (state_q.size() == 0) begin
                        chk("state_expected", state_q.size(), 1);
                    end else begin
                        mon_s = state_q.pop_front();
                        chk("button", button, mon_s.btn);
                        chk("multi_press", multi_press, mon_s.mp);
                        chk("key_code", key_code, mon_s.code);
                    end
                end
                if (key_valid) begin
                    if (pulse_q.size() == 0) begin
                        chk("unexpected_key_valid", key_valid, 0);
                    end else begin
                        mon_p = pulse_q.pop_front();
                        chk("key_valid_cycle", mon_n, mon_p.n);
                        chk("key_valid_code", key_code, mon_p.code);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit (bad=%0d)", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] f;
        int          a;
        int          b;
        int          kind;
        int          len;
        reset = 1'b1;
        keys  = '0;
        do_reset(3);

        run_hold(16'h0020, 14);
        run_hold(16'h0000, 5);
        run_hold(16'h0200, 2);
        run_hold(16'h0000, 1);
        run_hold(16'h0200, 2);
        run_hold(16'h0000, 4);
        run_hold(16'h8001, 5);
        run_hold(16'h8000, 5);
        run_hold(16'h0000, 4);

        for (int i = 0; i < 25; i++) begin
            kind = $urandom_range(0, 2);
            len  = $urandom_range(1, 6);
            a    = $urandom_range(0, 15);
            b    = (a + $urandom_range(1, 15)) % 16;
            f    = '0;
            if (kind >= 1) f[a] = 1'b1;
            if (kind == 2) f[b] = 1'b1;
            run_hold(f, len);
        end

        run_hold(16'h0000, 4);
        run_hold(16'h0008, 5);
        repeat (7) @(posedge clk_i);
        #2;
        do_reset(2);
        run_hold(16'h0008, 5);
        run_hold(16'h0000, 2);

        @(negedge clk_i);
        #1;
        chk("pulse_q_drained", pulse_q.size(), 0);
        chk("state_q_drained", state_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
